// File: rtl/fb_write_arbiter_if.sv
// rtl/fb_write_arbiter_if.sv - host pixel-write handshake into the frame buffer write arbiter
interface fb_write_arbiter_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 4
);
  logic                  host_req_i;
  logic [ADDR_WIDTH-1:0] host_addr_i;
  logic [DATA_WIDTH-1:0] host_data_i;
  logic                  host_ack_o;

  modport master (output host_req_i, host_addr_i, host_data_i, input host_ack_o);
  modport slave  (input host_req_i, host_addr_i, host_data_i, output host_ack_o);
endinterface

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - round-robin scheduler of host writes and rectangle fills onto frame buffer port A
module fb_write_arbiter #(
  parameter int H_RES         = 640,
  parameter int V_RES         = 480,
  parameter int ADDR_WIDTH    = $clog2(H_RES*V_RES),
  parameter int DATA_WIDTH    = 4,
  parameter int COORD_WIDTH   = 10,
  parameter bit WR_BLANK_ONLY = 1'b0
) (
  input  logic                   pxl_clk,
  input  logic                   rst,
  input  logic                   blank_i,
  fb_write_arbiter_if.slave      host,
  input  logic                   fill_start_i,
  input  logic [COORD_WIDTH-1:0] fill_x0_i,
  input  logic [COORD_WIDTH-1:0] fill_y0_i,
  input  logic [COORD_WIDTH-1:0] fill_w_i,
  input  logic [COORD_WIDTH-1:0] fill_h_i,
  input  logic [DATA_WIDTH-1:0]  fill_color_i,
  output logic                   fill_busy_o,
  output logic                   fill_done_o,
  output logic [ADDR_WIDTH-1:0]  fb_addr_o,
  output logic [DATA_WIDTH-1:0]  fb_data_o,
  output logic                   fb_en_o,
  output logic                   fb_we_o
);
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int CW1 = COORD_WIDTH + 1;
  localparam logic [CW1-1:0] H_LIM  = CW1'(H_RES);
  localparam logic [CW1-1:0] V_LIM  = CW1'(V_RES);
  localparam logic [AW1-1:0] STRIDE = AW1'(H_RES);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

  state_t                 state;
  logic [COORD_WIDTH-1:0] x0, y0, w, h, x, y;
  logic [DATA_WIDTH-1:0]  color;
  logic [CW1-1:0]         x_last, y_last;
  logic [AW1-1:0]         row_base;
  logic [ADDR_WIDTH-1:0]  addr;
  logic                   last_fill;

  logic [CW1-1:0] x_sum, y_sum, x_end, y_end;
  logic [AW1-1:0] row_base_setup, row_base_next;
  logic           empty_rect, wr_ok, fill_req, grant_host, grant_fill;

  assign x_sum          = {1'b0, x0} + {1'b0, w};
  assign y_sum          = {1'b0, y0} + {1'b0, h};
  assign x_end          = (x_sum > H_LIM) ? H_LIM : x_sum;
  assign y_end          = (y_sum > V_LIM) ? V_LIM : y_sum;
  assign empty_rect     = (w == '0) || (h == '0) || ({1'b0, x0} >= H_LIM) || ({1'b0, y0} >= V_LIM);
  assign row_base_setup = AW1'(y0) * STRIDE + AW1'(x0);
  assign row_base_next  = row_base + STRIDE;

  // last_fill=1 means the fill won most recently, so the host takes the next tie
  assign wr_ok      = !WR_BLANK_ONLY || blank_i;
  assign fill_req   = (state == RUN);
  assign grant_host = !rst && wr_ok && host.host_req_i && (!fill_req || last_fill);
  assign grant_fill = wr_ok && fill_req && (!host.host_req_i || !last_fill);

  assign host.host_ack_o = grant_host;
  assign fill_busy_o     = (state != IDLE);
  assign fill_done_o     = (state == DONE);

  always_ff @(posedge pxl_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x0        <= '0;
      y0        <= '0;
      w         <= '0;
      h         <= '0;
      x         <= '0;
      y         <= '0;
      color     <= '0;
      x_last    <= '0;
      y_last    <= '0;
      row_base  <= '0;
      addr      <= '0;
      last_fill <= 1'b1;
      fb_addr_o <= '0;
      fb_data_o <= '0;
      fb_en_o   <= 1'b0;
      fb_we_o   <= 1'b0;
    end else begin
      if (grant_host || grant_fill) last_fill <= grant_fill;
      fb_en_o <= grant_host || grant_fill;
      fb_we_o <= grant_host || grant_fill;
      if (grant_host) begin
        fb_addr_o <= host.host_addr_i;
        fb_data_o <= host.host_data_i;
      end else if (grant_fill) begin
        fb_addr_o <= addr;
        fb_data_o <= color;
      end

      case (state)
        IDLE: begin
          if (fill_start_i) begin
            x0    <= fill_x0_i;
            y0    <= fill_y0_i;
            w     <= fill_w_i;
            h     <= fill_h_i;
            color <= fill_color_i;
            state <= SETUP;
          end
        end
        SETUP: begin
          x        <= x0;
          y        <= y0;
          x_last   <= x_end - CW1'(1);
          y_last   <= y_end - CW1'(1);
          row_base <= row_base_setup;
          addr     <= row_base_setup[ADDR_WIDTH-1:0];
          state    <= empty_rect ? DONE : RUN;
        end
        RUN: begin
          if (grant_fill) begin
            if ({1'b0, x} == x_last) begin
              if ({1'b0, y} == y_last) begin
                state <= DONE;
              end else begin
                y        <= y + COORD_WIDTH'(1);
                x        <= x0;
                row_base <= row_base_next;
                addr     <= row_base_next[ADDR_WIDTH-1:0];
              end
            end else begin
              x    <= x + COORD_WIDTH'(1);
              addr <= addr + ADDR_WIDTH'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
